// File: rtl/condicionador_botoes_pkg.sv
// Shared types and helpers for the button conditioning stage.
// Channel FSM encoding, default channel count and a clog2 helper.
package condicionador_botoes_pkg;

  typedef enum logic [1:0] {
    ESTAVEL_0  = 2'd0,
    CONFIRMA_1 = 2'd1,
    ESTAVEL_1  = 2'd2,
    CONFIRMA_0 = 2'd3
  } estado_t;

  localparam int N_BOTOES_PADRAO = 8;

  // Minimum bits needed to hold 0..valor-1 (never less than 1).
  function automatic int clog2(input int valor);
    int r;
    int v;
    r = 0;
    v = valor - 1;
    for (int k = 0; k < 32; k++) begin
      if (v > 0) begin
        r = r + 1;
        v = v >> 1;
      end
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/condicionador_botoes_debounce_canal.sv
// One button channel: 2-flop synchronizer, debounce FSM, press pulse.
// AUTO_REPETICAO_EN adds a repeat counter re-pulsing while held.
module debounce_canal
  import condicionador_botoes_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS  = 1_000_000,
  parameter int REPETICAO_CICLOS = 12_500_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic botao_i,
  output logic estavel_o,
  output logic pulso_o
);

  localparam int CW = clog2(DEBOUNCE_CICLOS);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);

  logic [1:0]    sync_q;
  estado_t       estado_q;
  logic [CW-1:0] cnt_q;
  logic          estavel_q;
  logic          pulso_q;
  logic          sinc;
  logic          cnt_fim;

  assign sinc    = sync_q[1];
  assign cnt_fim = (cnt_q == CNT_MAX);

`ifdef AUTO_REPETICAO_EN
  localparam int RW = clog2(REPETICAO_CICLOS);
  localparam logic [RW-1:0] REP_MAX = RW'(REPETICAO_CICLOS - 1);

  logic [RW-1:0] rep_q;
  logic          segurando;
  logic          entra_0;

  // Accepted release wins over a repeat landing on the same edge.
  assign entra_0   = (estado_q == CONFIRMA_0) && !sinc && cnt_fim;
  assign segurando = (estado_q == ESTAVEL_1) ||
                     (estado_q == CONFIRMA_0);
`endif

  // Synchronizer, confirmation FSM and registered level/pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q    <= 2'b00;
      estado_q  <= ESTAVEL_0;
      cnt_q     <= '0;
      estavel_q <= 1'b0;
      pulso_q   <= 1'b0;
`ifdef AUTO_REPETICAO_EN
      rep_q     <= '0;
`endif
    end else begin
      sync_q  <= {sync_q[0], botao_i};
      pulso_q <= 1'b0;
      unique case (estado_q)
        ESTAVEL_0: begin
          if (sinc) begin
            estado_q <= CONFIRMA_1;
            cnt_q    <= CW'(1);
          end
        end
        CONFIRMA_1: begin
          if (!sinc) begin
            estado_q <= ESTAVEL_0;
            cnt_q    <= '0;
          end else if (cnt_fim) begin
            estado_q  <= ESTAVEL_1;
            cnt_q     <= '0;
            estavel_q <= 1'b1;
            pulso_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ESTAVEL_1: begin
          if (!sinc) begin
            estado_q <= CONFIRMA_0;
            cnt_q    <= CW'(1);
          end
        end
        CONFIRMA_0: begin
          if (sinc) begin
            estado_q <= ESTAVEL_1;
            cnt_q    <= '0;
          end else if (cnt_fim) begin
            estado_q  <= ESTAVEL_0;
            cnt_q     <= '0;
            estavel_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          estado_q <= ESTAVEL_0;
          cnt_q    <= '0;
        end
      endcase
`ifdef AUTO_REPETICAO_EN
      if (entra_0) begin
        rep_q <= '0;
      end else if (segurando) begin
        if (rep_q == REP_MAX) begin
          rep_q   <= '0;
          pulso_q <= 1'b1;
        end else begin
          rep_q <= rep_q + RW'(1);
        end
      end
`endif
    end
  end

  assign estavel_o = estavel_q;
  assign pulso_o   = pulso_q;

endmodule

// File: rtl/condicionador_botoes.sv
// Button input stage: N debounced channels plus any/index/multi flags.
// Optional auto-repeat is enabled by defining AUTO_REPETICAO_EN.
module condicionador_botoes
  import condicionador_botoes_pkg::*;
#(
  parameter int N_BOTOES         = N_BOTOES_PADRAO,
  parameter int DEBOUNCE_CICLOS  = 1_000_000,
  parameter int REPETICAO_CICLOS = 12_500_000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes,
  output logic [N_BOTOES-1:0] botoes_estaveis,
  output logic [N_BOTOES-1:0] pulso_botoes,
  output logic                algum_pulso,
  output logic [2:0]          botao_indice,
  output logic                multiplo
);

  for (genvar i = 0; i < N_BOTOES; i++) begin : g_canal
    debounce_canal #(
      .DEBOUNCE_CICLOS  (DEBOUNCE_CICLOS),
      .REPETICAO_CICLOS (REPETICAO_CICLOS)
    ) u_canal (
      .clk_i     (clock),
      .rst_ni    (reset),
      .botao_i   (botoes[i]),
      .estavel_o (botoes_estaveis[i]),
      .pulso_o   (pulso_botoes[i])
    );
  end

  assign algum_pulso = |pulso_botoes;

  // Clearing the lowest set bit leaves something only if 2+ were set.
  assign multiplo =
    |(pulso_botoes & (pulso_botoes - N_BOTOES'(1)));

  // Lowest-numbered pulsing button; scan high to low so low wins.
  always_comb begin
    botao_indice = 3'd0;
    for (int i = N_BOTOES - 1; i >= 0; i--) begin
      if (pulso_botoes[i]) begin
        botao_indice = 3'(i);
      end
    end
  end

endmodule

// File: tb/tb_condicionador_botoes.sv
// Bench for condicionador_botoes with DEBOUNCE=4, REPETICAO=8.
// Reference model plus directed literal expectations.
module tb_condicionador_botoes;

  localparam int DEB = 4;
  localparam int REPC = 8;
`ifdef AUTO_REPETICAO_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic       clock;
  logic       reset;
  logic [7:0] botoes;
  logic [7:0] botoes_estaveis;
  logic [7:0] pulso_botoes;
  logic       algum_pulso;
  logic [2:0] botao_indice;
  logic       multiplo;

  int checks = 0;
  int errors = 0;
  bit armed = 1'b0;

  condicionador_botoes #(
    .N_BOTOES         (8),
    .DEBOUNCE_CICLOS  (DEB),
    .REPETICAO_CICLOS (REPC)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .botoes          (botoes),
    .botoes_estaveis (botoes_estaveis),
    .pulso_botoes    (pulso_botoes),
    .algum_pulso     (algum_pulso),
    .botao_indice    (botao_indice),
    .multiplo        (multiplo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: raw level delayed 2 cycles; a level is accepted after it
  // differs from the accepted one for DEB straight cycles.
  logic [7:0] m_d1, m_d2;
  logic [7:0] m_stab, m_pulse;
  int         m_run[8];
  int         m_age[8];

  always @(posedge clock) begin
    if (!reset) begin
      m_d1 = 8'h00;
      m_d2 = 8'h00;
      m_stab = 8'h00;
      m_pulse = 8'h00;
      for (int i = 0; i < 8; i++) begin
        m_run[i] = 0;
        m_age[i] = 0;
      end
    end else begin
      m_pulse = 8'h00;
      for (int i = 0; i < 8; i++) begin
        bit was_held;
        bit fell;
        was_held = m_stab[i];
        fell = 1'b0;
        if (m_d2[i] != m_stab[i]) m_run[i] = m_run[i] + 1;
        else m_run[i] = 0;
        if (m_run[i] == DEB) begin
          m_run[i] = 0;
          m_stab[i] = ~m_stab[i];
          if (m_stab[i]) begin
            m_pulse[i] = 1'b1;
            m_age[i] = 0;
          end else begin
            fell = 1'b1;
          end
        end
        if (REP && was_held && !fell) begin
          m_age[i] = m_age[i] + 1;
          if (m_age[i] == REPC) begin
            m_age[i] = 0;
            m_pulse[i] = 1'b1;
          end
        end
      end
      m_d2 = m_d1;
      m_d1 = botoes;
    end
  end

  function automatic logic [2:0] low_idx(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) if (v[i]) r = 3'(i);
    return r;
  endfunction

  task automatic cmp(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t got %0h want %0h",
               name, $time, act, exp);
    end
  endtask

  // Every cycle after reset is first applied, DUT must match model.
  always @(negedge clock) begin
    if (armed) begin
      cmp("model_pulso", 32'(pulso_botoes), 32'(m_pulse));
      cmp("model_estaveis", 32'(botoes_estaveis), 32'(m_stab));
      cmp("model_algum", 32'(algum_pulso), 32'(|m_pulse));
      cmp("model_indice", 32'(botao_indice),
          32'(low_idx(m_pulse)));
      cmp("model_multiplo", 32'(multiplo),
          32'($countones(m_pulse) > 1));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Press mask, expect its one pulse exactly 6 cycles later.
  task automatic press(input string nm, input logic [7:0] mask,
                       input logic [2:0] idx, input logic mult);
    botoes = mask;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      cmp({nm, "_pulso"}, 32'(pulso_botoes),
          (k == 6) ? 32'(mask) : 32'h0);
      cmp({nm, "_estaveis"}, 32'(botoes_estaveis),
          (k == 6) ? 32'(mask) : 32'h0);
    end
    cmp({nm, "_algum"}, 32'(algum_pulso), 32'h1);
    cmp({nm, "_indice"}, 32'(botao_indice), 32'(idx));
    cmp({nm, "_multiplo"}, 32'(multiplo), 32'(mult));
    tick(1);
    cmp({nm, "_pulso_off"}, 32'(pulso_botoes), 32'h0);
    cmp({nm, "_held"}, 32'(botoes_estaveis), 32'(mask));
  endtask

  // Release everything; no pulse may appear on release.
  task automatic release_all(input string nm);
    botoes = 8'h00;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      cmp({nm, "_rel_pulso"}, 32'(pulso_botoes), 32'h0);
    end
    cmp({nm, "_rel_estaveis"}, 32'(botoes_estaveis), 32'h0);
  endtask

  initial begin
    reset = 1'b0;
    botoes = 8'hFF;
    tick(1);
    armed = 1'b1;
    tick(2);
    cmp("rst_estaveis", 32'(botoes_estaveis), 32'h0);
    cmp("rst_pulso", 32'(pulso_botoes), 32'h0);
    cmp("rst_algum", 32'(algum_pulso), 32'h0);
    cmp("rst_indice", 32'(botao_indice), 32'h0);
    cmp("rst_multiplo", 32'(multiplo), 32'h0);
    reset = 1'b1;
    press("all", 8'hFF, 3'd0, 1'b1);
    release_all("all");

    press("b3", 8'h08, 3'd3, 1'b0);
    release_all("b3");

    for (int k = 0; k < 4; k++) begin
      botoes = (k % 2 == 0) ? 8'h20 : 8'h00;
      tick(1);
      cmp("bounce_quiet", 32'(pulso_botoes), 32'h0);
    end
    press("bounce", 8'h20, 3'd5, 1'b0);
    release_all("bounce");

    botoes = 8'h80;
    tick(3);
    botoes = 8'h00;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      cmp("glitch_pulso", 32'(pulso_botoes), 32'h0);
      cmp("glitch_estaveis", 32'(botoes_estaveis), 32'h0);
    end

    press("simul", 8'h44, 3'd2, 1'b1);
    release_all("simul");

    botoes = 8'h02;
    tick(4);
    cmp("midrst_pre", 32'(pulso_botoes), 32'h0);
    reset = 1'b0;
    tick(1);
    cmp("midrst_pulso", 32'(pulso_botoes), 32'h0);
    cmp("midrst_estaveis", 32'(botoes_estaveis), 32'h0);
    reset = 1'b1;
    press("midrst", 8'h02, 3'd1, 1'b0);
    release_all("midrst");

    botoes = 8'h01;
    for (int k = 1; k <= 40; k++) begin
      bit e;
      tick(1);
      e = (k == 6) || (REP && k > 6 && ((k - 6) % REPC) == 0);
      cmp("hold_pulso", 32'(pulso_botoes), e ? 32'h1 : 32'h0);
    end
    release_all("hold");

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/condicionador_botoes.md
Name: condicionador_botoes

Overview:
- Upstream input stage for the LED-matrix puzzle datapath. Takes the 8 raw board buttons and replaces the separate debouncer and edge detectors.
- Per button: synchronizes the input, debounces it with a per-button confirmation counter, and emits a one-cycle press pulse.
- Also produces an OR-ed "any press" strobe, used as the debug-register enable, and an encoded index of the pressed button.

Parameters:
- N_BOTOES, 8: number of button channels; index outputs are sized for 8.
- DEBOUNCE_CICLOS, 1_000_000: consecutive cycles a synchronized level must hold before it is accepted (20 ms at 50 MHz); legal range 2..2^24.
- REPETICAO_CICLOS, 12_500_000: auto-repeat period; used only when AUTO_REPETICAO_EN is defined.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low; reset=0 at a rising edge clears all state.
- botoes  in  N_BOTOES  raw asynchronous button levels, 1 = pressed.
- botoes_estaveis  out  N_BOTOES  debounced levels.
- pulso_botoes  out  N_BOTOES  one-cycle press pulse per button.
- algum_pulso  out  1  OR of pulso_botoes.
- botao_indice  out  3  index of the lowest-numbered button pulsing this cycle; 0 when none.
- multiplo  out  1  more than one bit of pulso_botoes set in the same cycle.

Behaviour:
- Reset (reset=0): all synchronizer flops, counters and FSMs clear; every output is 0 the cycle after.
- Synchronizer: 2-flop chain per bit; sync[i] lags botoes[i] by 2 cycles.
- Per-channel FSM, with states ESTAVEL_0, CONFIRMA_1, ESTAVEL_1, CONFIRMA_0. Reset state is ESTAVEL_0.
  - ESTAVEL_0, sync=1 -> CONFIRMA_1; counter is loaded with 1.
  - CONFIRMA_1, sync=0 -> ESTAVEL_0; counter cleared (bounce rejected).
  - CONFIRMA_1, sync=1 and counter=DEBOUNCE_CICLOS-1 -> ESTAVEL_1. In the same edge, botoes_estaveis[i] goes to 1 and pulso_botoes[i] is registered as 1 for exactly one cycle.
  - CONFIRMA_1, sync=1 otherwise: counter increments.
  - ESTAVEL_1 and CONFIRMA_0 mirror the above. Release produces no pulse.
- Latency: from a clean botoes edge, 2 + DEBOUNCE_CICLOS cycles until botoes_estaveis and pulso_botoes change.
- Counter width is clog2(DEBOUNCE_CICLOS). The counter never wraps; it is cleared on every state exit.
- Glitch boundary: a level shorter than DEBOUNCE_CICLOS sync cycles produces no output change.
- Pulse rules:
  - A held button yields exactly one pulse.
  - Re-press requires a full accepted release first.
- Outputs algum_pulso, botao_indice and multiplo are combinational from the registered pulso_botoes, so they are valid in the same cycle as the pulse.
- Simultaneous pulses: botao_indice takes the lowest index, multiplo=1, and all pulse bits stay visible.
- Reset mid-confirmation: the channel drops to ESTAVEL_0 with no pulse. A button still held after reset is re-qualified and pulses once.
- Channels are fully independent; no shared counters.

Optional Feature:
- Macro: AUTO_REPETICAO_EN.
- Defined:
  - Each channel has a repeat counter that runs while in ESTAVEL_1 or CONFIRMA_0.
  - On reaching REPETICAO_CICLOS-1 it wraps to 0 and re-asserts pulso_botoes[i] for one cycle.
  - The first repeat comes REPETICAO_CICLOS cycles after the initial press pulse.
  - The counter clears on entry to ESTAVEL_0 and on reset.
- Undefined: no repeat counter is synthesized and exactly one pulse is produced per press.

Decomposition:
- Shared package holds:
  - the 2-bit state enum (ESTAVEL_0=0, CONFIRMA_1=1, ESTAVEL_1=2, CONFIRMA_0=3);
  - constant N_BOTOES_PADRAO=8;
  - a clog2 helper function.
- One sub-module, debounce_canal: synchronizer, FSM, counter and optional repeat logic for a single bit. It is generated N_BOTOES times.
- The top level holds only the generate loop and the OR/priority encoder.

Test Plan:
All scenarios use DEBOUNCE_CICLOS=4 and REPETICAO_CICLOS=8.
- Reset: hold reset=0 for 3 cycles with botoes=8'hFF -> all outputs 0; after release, one pulse per bit, all pulsing together, multiplo=1, botao_indice=0.
- Clean press of botoes[3] at cycle t:
  - pulso_botoes=8'h08 for exactly cycle t+6, with algum_pulso=1 and botao_indice=3;
  - botoes_estaveis[3]=1 from t+6;
  - release gives no pulse.
- Bounce: botoes[5] toggles 1,0,1,0 in single cycles, then holds 1 -> exactly one pulse, 6 cycles after the final rise; no earlier change.
- Simultaneous press of bits 2 and 6 -> pulso_botoes=8'h44, botao_indice=2, multiplo=1 for one cycle.
- Reset mid-confirm: bit 1 pressed; reset=0 at the third confirm cycle -> no pulse. Button still held after reset -> a single pulse 6 cycles after reset release.
- With AUTO_REPETICAO_EN: hold bit 0 for 40 cycles -> pulses at t+6, t+14, t+22, t+30, t+38. Without the macro -> only the t+6 pulse.
